// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the single-port SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned DEPTH_DEF  = 128;
    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 4;

    // INIT clears the array (when enabled), RUN arbitrates the port.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_resp_hold.sv
// One-entry bypass/hold register for SRAM read data on a valid/ready channel.
// Fresh read data passes straight through; if the consumer stalls it is
// captured and replayed until the handshake completes.
module sram_resp_hold
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              held;
    logic [DATA_W-1:0] hold_data;

    // Capture bypass data on a stalled cycle, release on handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            held      <= 1'b0;
            hold_data <= '0;
        end else if (cap_valid && !out_ready) begin
            held      <= 1'b1;
            hold_data <= cap_data;
        end else if (held && out_ready) begin
            held      <= 1'b0;
        end
    end

    // Held data takes priority over the macro's output.
    always_comb begin
        out_valid = cap_valid | held;
        out_data  = held ? hold_data : cap_data;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Front-end controller for a single-port masked-write SRAM macro: zero-fills
// the array after reset, then round-robins the port between a write and a
// read requester and returns read data on a stall-safe response channel.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned INIT_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] w_mask,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // One extra bit so the terminal count never aliases to zero.
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic        DO_INIT = (INIT_EN != 0);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              rr;
    logic              rr_nxt;
    logic              rd_pend;
    logic              port_open;
    logic              w_elig;
    logic              r_elig;
    logic              gnt_w;
    logic              gnt_r;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    // State, sweep counter, round-robin bit and read-in-flight flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= INIT;
            cnt     <= '0;
            rr      <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rr      <= rr_nxt;
            rd_pend <= gnt_r;
        end
    end

    // Next state, init sweep, arbitration and macro drive.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_nxt     = rr;
        port_open  = 1'b0;
        w_elig     = 1'b0;
        r_elig     = 1'b0;
        gnt_w      = 1'b0;
        gnt_r      = 1'b0;
        init_done  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;

        if (!reset) begin
            case (state)
                INIT: begin
                    if (DO_INIT) begin
                        sram_en    = 1'b1;
                        sram_wmode = 1'b1;
                        sram_addr  = cnt[ADDR_W-1:0];
                        sram_wmask = '1;
                        sram_wdata = '0;
                        cnt_nxt    = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state_nxt = RUN;
                        end
                    end else begin
                        // No fill: the port is usable straight out of reset.
                        port_open = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    port_open = 1'b1;
                end
                default: begin
                    state_nxt = INIT;
                end
            endcase

            if (port_open) begin
                init_done = 1'b1;
                w_elig    = w_valid;
                // A read may only issue if its response slot frees up this cycle.
                r_elig    = r_valid && (!hold_valid || resp_ready);

                if (w_elig && r_elig) begin
                    gnt_w  = !rr;
                    gnt_r  = rr;
                    rr_nxt = !rr;
                end else begin
                    gnt_w = w_elig;
                    gnt_r = r_elig;
                end

                if (gnt_w) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = w_addr;
                    sram_wmask = w_mask;
                    sram_wdata = w_data;
                end else if (gnt_r) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b0;
                    sram_addr  = r_addr;
                end
            end
        end
    end

    sram_resp_hold #(
        .DATA_W (DATA_W)
    ) u_resp_hold (
        .clock     (clock),
        .reset     (reset),
        .cap_valid (rd_pend),
        .cap_data  (sram_rdata),
        .out_ready (resp_ready),
        .out_valid (hold_valid),
        .out_data  (hold_data)
    );

    // Handshake and response outputs, forced low while reset is asserted.
    always_comb begin
        w_ready    = gnt_w;
        r_ready    = gnt_r;
        resp_valid = 1'b0;
        resp_data  = '0;
        if (!reset) begin
            resp_valid = hold_valid;
            resp_data  = hold_data;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro,
// a reference memory and a read-response scoreboard.
module tb_sram_port_arbiter;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 4;

    logic              clock;
    logic              reset;
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_mask;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    sram_port_arbiter #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INIT_EN (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_mask     (w_mask),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_addr     (r_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural macro: masked write, registered read data.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode)
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else
                sram_rdata <= mem[sram_addr];
        end
    end

    // Non-zero power-up contents so the clear sweep is observable.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i) ^ 4'h5;
        sram_rdata <= 4'h7;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_rsp = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] q [$];
    logic              ev;
    logic              chk_grant;
    logic              exp_w;
    logic              exp_r;

    typedef struct packed {
        logic              wv;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] wm;
        logic              rv;
        logic [ADDR_W-1:0] ra;
        logic              ew;
        logic              er;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare outputs for the current cycle and advance the models.
    task automatic sample();
        logic [DATA_W-1:0] e;
        if (reset) begin
            chk("rst_w_ready", 32'(w_ready), 0);
            chk("rst_r_ready", 32'(r_ready), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_data", 32'(resp_data), 0);
            chk("rst_init_done", 32'(init_done), 0);
            chk("rst_sram_en", 32'(sram_en), 0);
            chk("rst_sram_wmode", 32'(sram_wmode), 0);
            chk("rst_sram_addr", 32'(sram_addr), 0);
            chk("rst_sram_wmask", 32'(sram_wmask), 0);
            chk("rst_sram_wdata", 32'(sram_wdata), 0);
            q.delete();
            ev = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("one_grant", 32'(w_ready & r_ready), 0);
            if (chk_grant) begin
                chk("w_ready", 32'(w_ready), 32'(exp_w));
                chk("r_ready", 32'(r_ready), 32'(exp_r));
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 0);
                end else if (resp_ready) begin
                    e = q.pop_front();
                    n_rsp++;
                    chk("resp_data", 32'(resp_data), 32'(e));
                end else begin
                    e = q[0];
                    chk("resp_data_stall", 32'(resp_data), 32'(e));
                end
            end
            if (w_ready) begin
                chk("w_sram_en", 32'(sram_en), 1);
                chk("w_sram_wmode", 32'(sram_wmode), 1);
                chk("w_sram_addr", 32'(sram_addr), 32'(w_addr));
                chk("w_sram_wmask", 32'(sram_wmask), 32'(w_mask));
                chk("w_sram_wdata", 32'(sram_wdata), 32'(w_data));
            end else if (r_ready) begin
                chk("r_sram_en", 32'(sram_en), 1);
                chk("r_sram_wmode", 32'(sram_wmode), 0);
                chk("r_sram_addr", 32'(sram_addr), 32'(r_addr));
            end else begin
                chk("idle_sram_en", 32'(sram_en), 0);
            end
            ev = (r_valid && r_ready) || (ev && !resp_ready);
            if (r_valid && r_ready) begin
                q.push_back(ref_mem[r_addr]);
                n_acc++;
            end
            if (w_valid && w_ready)
                ref_mem[w_addr] = (ref_mem[w_addr] & ~w_mask) | (w_data & w_mask);
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] wm, input logic rv, input logic [ADDR_W-1:0] ra,
                         input logic rdy, input logic ew, input logic er);
        w_valid    = wv;
        w_addr     = wa;
        w_data     = wd;
        w_mask     = wm;
        r_valid    = rv;
        r_addr     = ra;
        resp_ready = rdy;
        exp_w      = ew;
        exp_r      = er;
        chk_grant  = 1'b1;
        step();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        w_valid    = 1'b1;
        w_addr     = 7'd9;
        w_data     = 4'hF;
        w_mask     = 4'hF;
        r_valid    = 1'b1;
        r_addr     = 7'd5;
        resp_ready = 1'b1;
        chk_grant  = 1'b0;
        step();
        step();
        reset   = 1'b0;
        w_valid = 1'b0;
        r_valid = 1'b1;
        r_addr  = 7'd5;
    endtask

    // Clear sweep: n cycles of zero writes; full sweep ends with a read of addr 5.
    task automatic init_seq(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("init_sram_en", 32'(sram_en), 1);
            chk("init_sram_wmode", 32'(sram_wmode), 1);
            chk("init_sram_addr", 32'(sram_addr), 32'(i));
            chk("init_sram_wmask", 32'(sram_wmask), 32'hF);
            chk("init_sram_wdata", 32'(sram_wdata), 0);
            chk("init_done_low", 32'(init_done), 0);
            chk("init_w_ready", 32'(w_ready), 0);
            chk("init_r_ready", 32'(r_ready), 0);
            @(posedge clock);
            #1;
        end
        if (full) begin
            @(negedge clock);
            chk("init_done_rise", 32'(init_done), 1);
            exp_w     = 1'b0;
            exp_r     = 1'b1;
            chk_grant = 1'b1;
            sample();
            chk_grant = 1'b0;
            @(posedge clock);
            #1;
            r_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ev        = 1'b0;
        chk_grant = 1'b0;
        exp_w     = 1'b0;
        exp_r     = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        //            wv  wa     wd    wm    rv  ra     ew  er
        vecs[0]  = '{1'b1, 7'd3,  4'hA, 4'hF, 1'b0, 7'd0,  1'b1, 1'b0};
        vecs[1]  = '{1'b0, 7'd0,  4'h0, 4'h0, 1'b1, 7'd3,  1'b0, 1'b1};
        vecs[2]  = '{1'b1, 7'd3,  4'h5, 4'h3, 1'b0, 7'd0,  1'b1, 1'b0};
        vecs[3]  = '{1'b0, 7'd0,  4'h0, 4'h0, 1'b1, 7'd3,  1'b0, 1'b1};
        vecs[4]  = '{1'b1, 7'd20, 4'h6, 4'hF, 1'b1, 7'd3,  1'b1, 1'b0};
        vecs[5]  = '{1'b1, 7'd21, 4'h7, 4'hF, 1'b1, 7'd20, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 7'd22, 4'h8, 4'hF, 1'b1, 7'd21, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 7'd23, 4'h9, 4'hF, 1'b1, 7'd22, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 7'd24, 4'hA, 4'hF, 1'b1, 7'd23, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 7'd25, 4'hB, 4'hF, 1'b1, 7'd24, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 7'd0,  4'h0, 4'h0, 1'b0, 7'd0,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 7'd0,  4'h0, 4'h0, 1'b1, 7'd3,  1'b0, 1'b1};
        vecs[12] = '{1'b1, 7'd3,  4'h0, 4'hF, 1'b0, 7'd0,  1'b1, 1'b0};
        vecs[13] = '{1'b0, 7'd0,  4'h0, 4'h0, 1'b1, 7'd3,  1'b0, 1'b1};

        do_reset();
        init_seq(DEPTH, 1'b1);

        // Directed vectors: masked writes, round-robin, read/write ordering.
        for (int k = 0; k < 14; k++)
            drive(vecs[k].wv, vecs[k].wa, vecs[k].wd, vecs[k].wm,
                  vecs[k].rv, vecs[k].ra, 1'b1, vecs[k].ew, vecs[k].er);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Stalled consumer with an overwrite of the address in flight.
        drive(1'b1, 7'd3, 4'hA, 4'hF, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 7'd3, 4'h0, 4'hF, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Back-to-back reads of freshly written addresses 0..7.
        for (int i = 0; i < 8; i++)
            drive(1'b1, ADDR_W'(i), DATA_W'(i * 3 + 1), 4'hF, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b1, ADDR_W'(i), 1'b1, 1'b0, 1'b1);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        chk("acc_vs_rsp", 32'(n_rsp), 32'(n_acc));

        // Reset with a response in flight, then reset again mid-sweep.
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b1, 7'd6, 1'b1, 1'b0, 1'b1);
        do_reset();
        init_seq(50, 1'b0);
        do_reset();
        init_seq(DEPTH, 1'b1);
        chk_grant = 1'b0;
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
